// File: rtl/min_row_reducer_pkg.sv
// Shared FSM encodings and sizing helpers for the attention-row minimum reducer.
// Encodings match the ones used by the other Min-based blocks in the datapath.
package min_row_reducer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Beat counter width; a single-beat row still needs a 1-bit counter.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/min_row_reducer_min.sv
// Combinational unsigned minimum over DATA_LENGTH packed elements (element 0 in the LSBs).
module min_row_reducer_min
    import min_row_reducer_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int DATA_LENGTH = 8
) (
    input  logic [DATA_WIDTH*DATA_LENGTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0]             o_min
);

    logic [DATA_WIDTH-1:0] w_min;

    always_comb begin
        w_min = i_data[0 +: DATA_WIDTH];
        for (int k = 1; k < DATA_LENGTH; k++) begin
            if (i_data[k*DATA_WIDTH +: DATA_WIDTH] < w_min) begin
                w_min = i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_min = w_min;

endmodule

// File: rtl/min_row_reducer.sv
// Streams one score row as LANES-wide beats through a small Min tree, folds the
// beat minima into a running accumulator and offers the row minimum on valid/ready.
module min_row_reducer
    import min_row_reducer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LANES      = 8,
    parameter int ROW_LEN    = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        abort,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH*LANES-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        busy
);

    localparam int BEATS = ROW_LEN / LANES;
    localparam int CNT_W = cnt_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    if ((ROW_LEN <= 0) || (ROW_LEN % LANES != 0)) begin : g_bad_row_len
        $fatal(1, "min_row_reducer: ROW_LEN must be a positive multiple of LANES");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [DATA_WIDTH-1:0] w_beat_min;
    logic [DATA_WIDTH-1:0] w_fold;
    logic                  w_accept;
    logic                  w_last_accum;

    min_row_reducer_min #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DATA_LENGTH (LANES)
    ) u_min (
        .i_data (in_data),
        .o_min  (w_beat_min)
    );

    // Ties keep the accumulator so the held value never toggles on equal data.
    assign w_fold       = (w_beat_min < r_acc) ? w_beat_min : r_acc;
    assign w_accept     = in_valid & in_ready & ~abort;
    assign w_last_accum = (r_state == ST_ACCUM) && (r_beat_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = (r_state != ST_HOLD);
        out_valid   = (r_state == ST_HOLD);
        busy        = (r_state != ST_IDLE);
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = (BEATS == 1) ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept && w_last_accum) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Accumulator, beat counter and the registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_out_data <= '0;
        end else if (abort) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            if (r_state == ST_IDLE) begin
                r_acc <= w_beat_min;
                if (BEATS == 1) begin
                    r_beat_cnt <= '0;
                    r_out_data <= w_beat_min;
                end else begin
                    r_beat_cnt <= CNT_W'(1);
                end
            end else begin
                r_acc <= w_fold;
                if (w_last_accum) begin
                    r_beat_cnt <= '0;
                    r_out_data <= w_fold;
                end else begin
                    r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out_data = r_out_data;

endmodule
